// File: rtl/rv32i_types_pkg.sv
// Shared RV32I pipeline types: forward-mux selects and hazard tracker entries.
package rv32i_types_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    MUX_F_A_RS1_DATA_D   = 2'd0,
    MUX_F_A_ALU_RESULT_M = 2'd1,
    MUX_F_A_ALU_RESULT_W = 2'd2,
    MUX_F_A_NONE         = 2'd3
  } mux_forward_A_enum;

  typedef enum logic [1:0] {
    MUX_F_B_RS2_DATA_D   = 2'd0,
    MUX_F_B_ALU_RESULT_M = 2'd1,
    MUX_F_B_ALU_RESULT_W = 2'd2,
    MUX_F_B_NONE         = 2'd3
  } mux_forward_B_enum;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } hazard_track_t;

  localparam hazard_track_t HAZARD_BUBBLE = '0;

  // An entry can supply a forwarded value for rs when it really writes that register.
  function automatic logic fwd_match(input hazard_track_t t, input logic [REG_IDX_W-1:0] rs);
    return t.valid & t.reg_write & (t.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_tracker.sv
// E/M/W destination metadata shift register; holds on mem_stall, inserts bubbles into E.
module hazard_tracker
  import rv32i_types_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      advance_i,
  input  logic                      bubble_i,
  input  hazard_track_t             dec_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
  input  logic                      uses_rs1_i,
  input  logic                      uses_rs2_i,
  output hazard_track_t             e_o,
  output hazard_track_t             m_o,
  output hazard_track_t             w_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_e_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_e_o,
  output logic                      uses_rs1_e_o,
  output logic                      uses_rs2_e_o
);

  hazard_track_t             e_q, e_d, m_q, m_d, w_q, w_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic                      u1_q, u1_d, u2_q, u2_d;

  always_comb begin
    e_d   = e_q;
    m_d   = m_q;
    w_d   = w_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    u1_d  = u1_q;
    u2_d  = u2_q;
    if (advance_i) begin
      w_d = m_q;
      m_d = e_q;
      if (bubble_i) begin
        e_d   = HAZARD_BUBBLE;
        rs1_d = '0;
        rs2_d = '0;
        u1_d  = 1'b0;
        u2_d  = 1'b0;
      end else begin
        e_d   = dec_i;
        rs1_d = rs1_i;
        rs2_d = rs2_i;
        u1_d  = uses_rs1_i;
        u2_d  = uses_rs2_i;
      end
    end else begin
      e_d = e_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q   <= HAZARD_BUBBLE;
      m_q   <= HAZARD_BUBBLE;
      w_q   <= HAZARD_BUBBLE;
      rs1_q <= '0;
      rs2_q <= '0;
      u1_q  <= 1'b0;
      u2_q  <= 1'b0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      u1_q  <= u1_d;
      u2_q  <= u2_d;
    end
  end

  assign e_o          = e_q;
  assign m_o          = m_q;
  assign w_o          = w_q;
  assign rs1_e_o      = rs1_q;
  assign rs2_e_o      = rs2_q;
  assign uses_rs1_e_o = u1_q;
  assign uses_rs2_e_o = u2_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Forwarding, load-use stall, redirect flush and mem_stall freeze control around execute,
// plus saturating stall/flush event counters.
module hazard_scheduler
  import rv32i_types_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNTER_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_D,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_D,
  input  logic                      uses_rs1_D,
  input  logic                      uses_rs2_D,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_D,
  input  logic                      reg_write_D,
  input  logic                      mem_read_D,
  input  logic                      redirect_E,
  input  logic                      mem_stall,
  output mux_forward_A_enum         mux_forward_A_select_E,
  output mux_forward_B_enum         mux_forward_B_select_E,
  output logic                      stall_F,
  output logic                      stall_D,
  output logic                      stall_EMW,
  output logic                      flush_D,
  output logic                      flush_E,
  output logic [COUNTER_WIDTH-1:0]  stall_count,
  output logic [COUNTER_WIDTH-1:0]  flush_count
);

  hazard_track_t             e_s, m_s, w_s, dec_s;
  logic [REG_ADDR_WIDTH-1:0] rs1_e_s, rs2_e_s;
  logic                      uses_rs1_e_s, uses_rs2_e_s;
  logic                      load_use_s, stall_hit_s, flush_hit_s;
  logic [COUNTER_WIDTH-1:0]  stall_count_q, stall_count_d, flush_count_q, flush_count_d;

  assign dec_s = '{valid: valid_D, rd: rd_addr_D, reg_write: reg_write_D, mem_read: mem_read_D};

  hazard_tracker #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_tracker (
    .clk_i        (clk),
    .rst_i        (rst),
    .advance_i    (!mem_stall),
    .bubble_i     (flush_E | !valid_D),
    .dec_i        (dec_s),
    .rs1_i        (rs1_addr_D),
    .rs2_i        (rs2_addr_D),
    .uses_rs1_i   (uses_rs1_D),
    .uses_rs2_i   (uses_rs2_D),
    .e_o          (e_s),
    .m_o          (m_s),
    .w_o          (w_s),
    .rs1_e_o      (rs1_e_s),
    .rs2_e_o      (rs2_e_s),
    .uses_rs1_e_o (uses_rs1_e_s),
    .uses_rs2_e_o (uses_rs2_e_s)
  );

  assign load_use_s = valid_D & e_s.valid & e_s.mem_read & (e_s.rd != '0) &
                      ((uses_rs1_D & (rs1_addr_D == e_s.rd)) | (uses_rs2_D & (rs2_addr_D == e_s.rd)));

  // Priority: reset, then mem_stall freeze, then redirect, then load-use.
  always_comb begin
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_EMW   = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    stall_hit_s = 1'b0;
    flush_hit_s = 1'b0;
    if (rst) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (mem_stall) begin
      stall_F   = 1'b1;
      stall_D   = 1'b1;
      stall_EMW = 1'b1;
    end else if (redirect_E) begin
      flush_D     = 1'b1;
      flush_E     = 1'b1;
      flush_hit_s = 1'b1;
    end else if (load_use_s) begin
      stall_F     = 1'b1;
      stall_D     = 1'b1;
      flush_E     = 1'b1;
      stall_hit_s = 1'b1;
    end else begin
      stall_F = 1'b0;
    end
  end

  // M beats W; x0 always reads the register file.
  always_comb begin
    mux_forward_A_select_E = MUX_F_A_RS1_DATA_D;
    mux_forward_B_select_E = MUX_F_B_RS2_DATA_D;
    if (rst) begin
      mux_forward_A_select_E = MUX_F_A_RS1_DATA_D;
      mux_forward_B_select_E = MUX_F_B_RS2_DATA_D;
    end else begin
      if (!uses_rs1_e_s)                mux_forward_A_select_E = MUX_F_A_NONE;
      else if (rs1_e_s == '0)           mux_forward_A_select_E = MUX_F_A_RS1_DATA_D;
      else if (fwd_match(m_s, rs1_e_s)) mux_forward_A_select_E = MUX_F_A_ALU_RESULT_M;
      else if (fwd_match(w_s, rs1_e_s)) mux_forward_A_select_E = MUX_F_A_ALU_RESULT_W;
      else                              mux_forward_A_select_E = MUX_F_A_RS1_DATA_D;
      if (!uses_rs2_e_s)                mux_forward_B_select_E = MUX_F_B_NONE;
      else if (rs2_e_s == '0)           mux_forward_B_select_E = MUX_F_B_RS2_DATA_D;
      else if (fwd_match(m_s, rs2_e_s)) mux_forward_B_select_E = MUX_F_B_ALU_RESULT_M;
      else if (fwd_match(w_s, rs2_e_s)) mux_forward_B_select_E = MUX_F_B_ALU_RESULT_W;
      else                              mux_forward_B_select_E = MUX_F_B_RS2_DATA_D;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_hit_s && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
    else                                      stall_count_d = stall_count_q;
    if (flush_hit_s && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
    else                                      flush_count_d = flush_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed-vector bench for hazard_scheduler with hand-computed expectations.
module tb_hazard_scheduler;
  import rv32i_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_D = 1'b0;
  logic [4:0] rs1_addr_D = 5'd0, rs2_addr_D = 5'd0, rd_addr_D = 5'd0;
  logic uses_rs1_D = 1'b0, uses_rs2_D = 1'b0, reg_write_D = 1'b0, mem_read_D = 1'b0;
  logic redirect_E = 1'b0, mem_stall = 1'b0;
  mux_forward_A_enum sel_a;
  mux_forward_B_enum sel_b;
  logic stall_F, stall_D, stall_EMW, flush_D, flush_E;
  logic [31:0] stall_count, flush_count;
  int checks = 0;
  int failures = 0;

  hazard_scheduler dut (
    .clk(clk), .rst(rst), .valid_D(valid_D),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .uses_rs1_D(uses_rs1_D), .uses_rs2_D(uses_rs2_D),
    .rd_addr_D(rd_addr_D), .reg_write_D(reg_write_D), .mem_read_D(mem_read_D),
    .redirect_E(redirect_E), .mem_stall(mem_stall),
    .mux_forward_A_select_E(sel_a), .mux_forward_B_select_E(sel_b),
    .stall_F(stall_F), .stall_D(stall_D), .stall_EMW(stall_EMW),
    .flush_D(flush_D), .flush_E(flush_E),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    valid_D = v; rs1_addr_D = r1; rs2_addr_D = r2; uses_rs1_D = u1; uses_rs2_D = u2;
    rd_addr_D = rd; reg_write_D = rw; mem_read_D = mr;
  endtask

  task automatic idle();
    set_d(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    redirect_E = 1'b0;
    mem_stall  = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    cyc(); cyc();
    mem_stall = 1'b1; #1;
    checks++; if (flush_D !== 1'b1) begin failures++; $display("FAIL rst_flush_D act=%0b exp=1", flush_D); end
    checks++; if (flush_E !== 1'b1) begin failures++; $display("FAIL rst_flush_E act=%0b exp=1", flush_E); end
    checks++; if (stall_EMW !== 1'b0) begin failures++; $display("FAIL rst_stall_EMW act=%0b exp=0", stall_EMW); end
    checks++; if (stall_F !== 1'b0) begin failures++; $display("FAIL rst_stall_F act=%0b exp=0", stall_F); end
    checks++; if (sel_a !== MUX_F_A_RS1_DATA_D) begin failures++; $display("FAIL rst_sel_a act=%0d exp=%0d", sel_a, MUX_F_A_RS1_DATA_D); end
    checks++; if (sel_b !== MUX_F_B_RS2_DATA_D) begin failures++; $display("FAIL rst_sel_b act=%0d exp=%0d", sel_b, MUX_F_B_RS2_DATA_D); end
    rst = 1'b0; idle(); #1;
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL rst_stall_count act=%0d exp=0", stall_count); end
    checks++; if (flush_count !== 32'd0) begin failures++; $display("FAIL rst_flush_count act=%0d exp=0", flush_count); end
    checks++; if (flush_D !== 1'b0 || flush_E !== 1'b0) begin failures++; $display("FAIL post_rst_flush act=%0b%0b exp=00", flush_D, flush_E); end
    checks++; if (sel_a !== MUX_F_A_NONE) begin failures++; $display("FAIL post_rst_sel_a act=%0d exp=%0d", sel_a, MUX_F_A_NONE); end
  endtask

  task automatic test_ex_forward();
    drain();
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); cyc();
    set_d(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); cyc();
    idle(); #1;
    checks++; if (sel_a !== MUX_F_A_ALU_RESULT_M) begin failures++; $display("FAIL fwd_m_a act=%0d exp=%0d", sel_a, MUX_F_A_ALU_RESULT_M); end
    checks++; if (sel_b !== MUX_F_B_RS2_DATA_D) begin failures++; $display("FAIL fwd_m_b act=%0d exp=%0d", sel_b, MUX_F_B_RS2_DATA_D); end
    drain();
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); cyc();
    idle(); cyc();
    set_d(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); cyc();
    idle(); #1;
    checks++; if (sel_a !== MUX_F_A_ALU_RESULT_W) begin failures++; $display("FAIL fwd_w_a act=%0d exp=%0d", sel_a, MUX_F_A_ALU_RESULT_W); end
    checks++; if (sel_b !== MUX_F_B_RS2_DATA_D) begin failures++; $display("FAIL fwd_w_b act=%0d exp=%0d", sel_b, MUX_F_B_RS2_DATA_D); end
  endtask

  task automatic test_x0_priority();
    drain();
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0); cyc();
    set_d(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); cyc();
    idle(); #1;
    checks++; if (sel_a !== MUX_F_A_RS1_DATA_D) begin failures++; $display("FAIL x0_sel_a act=%0d exp=%0d", sel_a, MUX_F_A_RS1_DATA_D); end
    checks++; if (sel_b !== MUX_F_B_RS2_DATA_D) begin failures++; $display("FAIL x0_sel_b act=%0d exp=%0d", sel_b, MUX_F_B_RS2_DATA_D); end
    drain();
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); cyc();
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0); cyc();
    set_d(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0); cyc();
    idle(); #1;
    checks++; if (sel_a !== MUX_F_A_ALU_RESULT_M) begin failures++; $display("FAIL prio_sel_a act=%0d exp=%0d", sel_a, MUX_F_A_ALU_RESULT_M); end
    checks++; if (sel_b !== MUX_F_B_ALU_RESULT_M) begin failures++; $display("FAIL prio_sel_b act=%0d exp=%0d", sel_b, MUX_F_B_ALU_RESULT_M); end
  endtask

  task automatic test_load_use();
    drain();
    set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); cyc();
    set_d(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); #1;
    checks++; if ({stall_F, stall_D, flush_E} !== 3'b111) begin failures++; $display("FAIL lu_stall act=%b exp=111", {stall_F, stall_D, flush_E}); end
    checks++; if ({flush_D, stall_EMW} !== 2'b00) begin failures++; $display("FAIL lu_noflushD act=%b exp=00", {flush_D, stall_EMW}); end
    cyc(); #1;
    checks++; if (stall_count !== 32'd1) begin failures++; $display("FAIL lu_count act=%0d exp=1", stall_count); end
    checks++; if ({stall_F, flush_E} !== 2'b00) begin failures++; $display("FAIL lu_one_cycle act=%b exp=00", {stall_F, flush_E}); end
    cyc(); idle(); #1;
    checks++; if (sel_a !== MUX_F_A_ALU_RESULT_W) begin failures++; $display("FAIL lu_sel_a act=%0d exp=%0d", sel_a, MUX_F_A_ALU_RESULT_W); end
    checks++; if (sel_b !== MUX_F_B_ALU_RESULT_W) begin failures++; $display("FAIL lu_sel_b act=%0d exp=%0d", sel_b, MUX_F_B_ALU_RESULT_W); end
    checks++; if (stall_count !== 32'd1) begin failures++; $display("FAIL lu_count_hold act=%0d exp=1", stall_count); end
  endtask

  task automatic test_redirect_vs_load_use();
    drain();
    set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); cyc();
    set_d(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0); redirect_E = 1'b1; #1;
    checks++; if ({flush_D, flush_E} !== 2'b11) begin failures++; $display("FAIL rd_flush act=%b exp=11", {flush_D, flush_E}); end
    checks++; if ({stall_F, stall_D} !== 2'b00) begin failures++; $display("FAIL rd_nostall act=%b exp=00", {stall_F, stall_D}); end
    cyc(); redirect_E = 1'b0; #1;
    checks++; if (flush_count !== 32'd1) begin failures++; $display("FAIL rd_flush_count act=%0d exp=1", flush_count); end
    checks++; if (stall_count !== 32'd1) begin failures++; $display("FAIL rd_stall_count act=%0d exp=1", stall_count); end
  endtask

  task automatic test_mem_stall();
    drain();
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); cyc();
    set_d(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0); cyc();
    set_d(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    mem_stall = 1'b1; redirect_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({stall_F, stall_D, stall_EMW} !== 3'b111) begin failures++; $display("FAIL ms_stall[%0d] act=%b exp=111", i, {stall_F, stall_D, stall_EMW}); end
      checks++; if ({flush_D, flush_E} !== 2'b00) begin failures++; $display("FAIL ms_noflush[%0d] act=%b exp=00", i, {flush_D, flush_E}); end
      checks++; if (sel_a !== MUX_F_A_ALU_RESULT_M) begin failures++; $display("FAIL ms_frozen[%0d] act=%0d exp=%0d", i, sel_a, MUX_F_A_ALU_RESULT_M); end
      cyc();
    end
    checks++; if (flush_count !== 32'd1) begin failures++; $display("FAIL ms_count_hold act=%0d exp=1", flush_count); end
    mem_stall = 1'b0; #1;
    checks++; if ({flush_D, flush_E, stall_F, stall_EMW} !== 4'b1100) begin failures++; $display("FAIL ms_release act=%b exp=1100", {flush_D, flush_E, stall_F, stall_EMW}); end
    cyc(); redirect_E = 1'b0; #1;
    checks++; if (flush_count !== 32'd2) begin failures++; $display("FAIL ms_flush_count act=%0d exp=2", flush_count); end
    checks++; if (sel_a !== MUX_F_A_NONE) begin failures++; $display("FAIL ms_bubble act=%0d exp=%0d", sel_a, MUX_F_A_NONE); end
  endtask

  task automatic test_reset_wins();
    drain();
    set_d(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); cyc();
    set_d(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    redirect_E = 1'b1; mem_stall = 1'b1; rst = 1'b1; #1;
    checks++; if ({stall_F, stall_D, stall_EMW} !== 3'b000) begin failures++; $display("FAIL rw_stall act=%b exp=000", {stall_F, stall_D, stall_EMW}); end
    checks++; if ({flush_D, flush_E} !== 2'b11) begin failures++; $display("FAIL rw_flush act=%b exp=11", {flush_D, flush_E}); end
    cyc(); rst = 1'b0; idle(); #1;
    checks++; if (stall_count !== 32'd0 || flush_count !== 32'd0) begin failures++; $display("FAIL rw_counters act=%0d/%0d exp=0/0", stall_count, flush_count); end
    checks++; if (sel_a !== MUX_F_A_NONE) begin failures++; $display("FAIL rw_tracker act=%0d exp=%0d", sel_a, MUX_F_A_NONE); end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_x0_priority();
    test_load_use();
    test_redirect_vs_load_use();
    test_mem_stall();
    test_reset_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline hazard controller for the RV32I 5-stage core. It owns the forwarding, stall and flush decisions around the execute stage.
- It keeps its own E/M/W shift register of destination-register metadata and drives the execute-stage forward-mux selects.
- It detects load-use hazards and control-transfer redirects, and generates F/D stalls and D/E flushes.
- It also keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- COUNTER_WIDTH, 32, width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- valid_D  in  1  decode stage holds a real instruction
- rs1_addr_D  in  REG_ADDR_WIDTH  decode source register 1
- rs2_addr_D  in  REG_ADDR_WIDTH  decode source register 2
- uses_rs1_D  in  1  decode instruction reads rs1
- uses_rs2_D  in  1  decode instruction reads rs2
- rd_addr_D  in  REG_ADDR_WIDTH  decode destination register
- reg_write_D  in  1  decode instruction writes rd
- mem_read_D  in  1  decode instruction is a load
- redirect_E  in  1  execute resolved a taken jump or branch this cycle
- mem_stall  in  1  data memory busy; freeze the whole pipeline
- mux_forward_A_select_E  out  mux_forward_A_enum  forward select for operand A in E
- mux_forward_B_select_E  out  mux_forward_B_enum  forward select for operand B in E
- stall_F  out  1  hold PC
- stall_D  out  1  hold F/D pipe register
- stall_EMW  out  1  hold D/E, E/M and M/W registers (equals mem_stall, 0 during rst)
- flush_D  out  1  clear F/D pipe register
- flush_E  out  1  clear D/E pipe register (insert bubble)
- stall_count  out  COUNTER_WIDTH  cycles with load-use stall
- flush_count  out  COUNTER_WIDTH  redirect flush events

Behaviour:
Reset
- rst=1 at a clock edge: all tracker entries become invalid and both counters become 0.
- While rst=1, the combinational outputs are forced: stall_F=stall_D=stall_EMW=0, flush_D=flush_E=1, forward selects = RS1_DATA_D / RS2_DATA_D.
- Reset asserted mid-stall or mid-redirect wins; no pending state survives it.

Tracker state
- Entries E, M and W each hold {valid, rd, reg_write, mem_read}.
- Entry E also holds {rs1, rs2, uses_rs1, uses_rs2}.
- Advance condition: mem_stall=0. Then W<=M, M<=E, and E<=(flush_E or !valid_D) ? bubble : decode fields.
- A bubble has valid=0 and every enable bit 0.
- mem_stall=1: all entries hold.

Forwarding (combinational from tracker, zero latency)
- Operand A, in priority order:
  - uses_rs1_E=0 -> MUX_F_A_NONE.
  - rs1_E==0 -> RS1_DATA_D.
  - M valid, reg_write, rd==rs1_E -> ALU_RESULT_M.
  - Else W valid, reg_write, rd==rs1_E -> ALU_RESULT_W.
  - Else -> RS1_DATA_D.
- Operand B is identical, using rs2 and the MUX_F_B_* values.
- x0 is never forwarded.

Load-use hazard
- load_use = valid_D & E.valid & E.mem_read & E.rd!=0 & ((uses_rs1_D & rs1_D==E.rd) | (uses_rs2_D & rs2_D==E.rd)).
- Response: stall_F=stall_D=1 and flush_E=1 for exactly one cycle. The load then sits in M, and the consumer later gets W forwarding.

Redirect
- redirect_E=1 -> flush_D=1, flush_E=1. stall_F and stall_D are suppressed, so the new PC fetches.
- Redirect has priority over load_use in the same cycle.

mem_stall
- Has priority over both of the above. It asserts stall_F, stall_D and stall_EMW; flush_D=flush_E=0 and no counter increments.
- A redirect or load_use pending in E/D is acted on in the first cycle with mem_stall=0.

Counters
- stall_count += 1 each cycle load_use is acted on.
- flush_count += 1 each cycle redirect is acted on.
- Both saturate at all-ones and never wrap.

Decomposition:
- rv32i_types_pkg gains:
  - hazard_track_t, a packed struct {valid, rd, reg_write, mem_read}.
  - HAZARD_BUBBLE, a constant all-zero entry.
- The existing mux_forward_A_enum and mux_forward_B_enum are reused.
- One natural sub-module, hazard_tracker: the three-entry shift register with hold and bubble insert.
- Decision logic and counters stay in hazard_scheduler.

Test Plan:
- Reset: hold rst 2 cycles, release with idle inputs -> counters 0, flush_D=flush_E=1 during rst and 0 after, selects RS1_DATA_D/RS2_DATA_D.
- EX forwarding: "add x5" followed by "sub x6,x5,x7" -> in the sub's E cycle, A select = ALU_RESULT_M and B select = RS2_DATA_D. Insert one nop between them -> A select = ALU_RESULT_W.
- x0 and priority:
  - A write to x0 followed by a reader of x0 -> no forwarding.
  - Two back-to-back writes to x3, then a reader -> ALU_RESULT_M selected.
- Load-use: "lw x4" followed by "add x8,x4,x4" -> one cycle of stall_F=stall_D=flush_E=1 and stall_count=1. Next cycle both selects = ALU_RESULT_W.
- Redirect vs load-use: redirect_E=1 in the same cycle as load_use -> flush_D=flush_E=1, stall_F=0, flush_count=1, stall_count unchanged.
- mem_stall: hold 3 cycles with a redirect pending -> no flush and tracker frozen during the hold. Flush occurs in the cycle after release.
